// File: rtl/mips_datapath_if.sv
// Host instruction-memory load bus for mips_datapath.
//   master: host side that drives program words.
//   slave : core side that receives them.
// Ports (all driven by master):
//   i_write_inst_mem  write strobe; when high, the core also stalls that cycle
//   i_inst_mem_addr   word address (only the low imem index bits are used)
//   i_inst_mem_data   instruction word to store
interface mips_datapath_if #(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32
);
    logic                        i_write_inst_mem;
    logic [PC_BITS-1:0]          i_inst_mem_addr;
    logic [INSTRUCTION_BITS-1:0] i_inst_mem_data;

    modport master (output i_write_inst_mem, output i_inst_mem_addr, output i_inst_mem_data);
    modport slave  (input  i_write_inst_mem, input  i_inst_mem_addr, input  i_inst_mem_data);
endinterface

// File: rtl/mips_datapath.sv
// Single-cycle, word-addressed MIPS-subset core: PC, host-loadable instruction
// memory, decoder, 32x32 register file, ALU and branch/jump logic.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (PC, registers, data memory)
//   enable     1 = retire one instruction per cycle, 0 = hold all state
//   host       mips_datapath_if.slave; a write stalls the core for that cycle
//   o_rf_regs  flat register file, reg k on [PROC_BITS*k +: PROC_BITS]
// Optional feature: define DATAPATH_DMEM_EN to add a 64-word data memory with
// LW/SW; without it LW and SW retire as NOPs.
module mips_datapath #(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int PROC_BITS        = 32,
    parameter int REG_ADDRS_BITS   = 5,
    parameter int OPCODE_BITS      = 6,
    parameter int IMEM_ADDR_BITS   = 8,
    parameter int DMEM_ADDR_BITS   = 6
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    mips_datapath_if.slave                            host,
    output logic [(2**REG_ADDRS_BITS)*PROC_BITS-1:0]  o_rf_regs
);
    localparam int NREGS = 2**REG_ADDRS_BITS;

    // opcodes
    localparam logic [OPCODE_BITS-1:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                                       OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                                       OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                                       OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    // R-type functs
    localparam logic [OPCODE_BITS-1:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03,
                                       FN_JR  = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                                       FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26,
                                       FN_NOR = 6'h27, FN_SLT  = 6'h2A;

    logic [INSTRUCTION_BITS-1:0] imem [2**IMEM_ADDR_BITS];
    logic [PROC_BITS-1:0]        rf   [NREGS];
    logic [PC_BITS-1:0]          pc;

    // ---------------- fetch / decode ----------------
    logic [INSTRUCTION_BITS-1:0] inst;
    logic [OPCODE_BITS-1:0]      opcode, funct;
    logic [REG_ADDRS_BITS-1:0]   rs, rt, rd;
    logic [4:0]                  shamt;
    logic [15:0]                 imm;
    logic [PROC_BITS-1:0]        rs_val, rt_val, imm_sx, imm_zx;
    logic [PC_BITS-1:0]          br_off;

    // PC counts freely; only its low bits index the memory, so it wraps there.
    assign inst   = imem[pc[IMEM_ADDR_BITS-1:0]];
    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign shamt  = inst[10:6];
    assign funct  = inst[5:0];
    assign imm    = inst[15:0];
    assign rs_val = rf[rs];   // rf[0] is never written, so r0 reads 0
    assign rt_val = rf[rt];
    assign imm_sx = {{(PROC_BITS-16){imm[15]}}, imm};
    assign imm_zx = {{(PROC_BITS-16){1'b0}}, imm};
    assign br_off = {{(PC_BITS-16){imm[15]}}, imm};

    // ---------------- data memory (optional) ----------------
`ifdef DATAPATH_DMEM_EN
    logic [PROC_BITS-1:0]      dmem [2**DMEM_ADDR_BITS];
    logic [PROC_BITS-1:0]      mem_addr;
    logic [DMEM_ADDR_BITS-1:0] mem_idx;
    logic                      unused_mem_addr;

    // byte address; low two bits ignored, bits above the depth wrap
    assign mem_addr        = rs_val + imm_sx;
    assign mem_idx         = mem_addr[DMEM_ADDR_BITS+1:2];
    assign unused_mem_addr = ^{mem_addr[PROC_BITS-1:DMEM_ADDR_BITS+2], mem_addr[1:0]};
`endif

    // ---------------- execute ----------------
    logic                      wr_en;
    logic [REG_ADDRS_BITS-1:0] wr_addr;
    logic [PROC_BITS-1:0]      wr_data;
    logic [PC_BITS-1:0]        next_pc;
    logic                      dmem_we;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rd;
        wr_data = '0;
        next_pc = pc + 1'b1;
        dmem_we = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (funct)
                    FN_SLL:  wr_data = rt_val << shamt;
                    FN_SRL:  wr_data = rt_val >> shamt;
                    FN_SRA:  wr_data = $signed(rt_val) >>> shamt;
                    FN_ADDU: wr_data = rs_val + rt_val;
                    FN_SUBU: wr_data = rs_val - rt_val;
                    FN_AND:  wr_data = rs_val & rt_val;
                    FN_OR:   wr_data = rs_val | rt_val;
                    FN_XOR:  wr_data = rs_val ^ rt_val;
                    FN_NOR:  wr_data = ~(rs_val | rt_val);
                    FN_SLT:  wr_data = {{(PROC_BITS-1){1'b0}}, $signed(rs_val) < $signed(rt_val)};
                    FN_JR: begin
                        wr_en   = 1'b0;
                        next_pc = PC_BITS'(rs_val);
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_ADDI: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val + imm_sx; end
            OP_SLTI: begin
                wr_en = 1'b1; wr_addr = rt;
                wr_data = {{(PROC_BITS-1){1'b0}}, $signed(rs_val) < $signed(imm_sx)};
            end
            OP_ANDI: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val & imm_zx; end
            OP_ORI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val | imm_zx; end
            OP_XORI: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val ^ imm_zx; end
            OP_LUI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = {imm, {(PROC_BITS-16){1'b0}}}; end
            OP_BEQ:  if (rs_val == rt_val) next_pc = pc + 1'b1 + br_off;
            OP_BNE:  if (rs_val != rt_val) next_pc = pc + 1'b1 + br_off;
            OP_J:    next_pc = {{(PC_BITS-26){1'b0}}, inst[25:0]};
`ifdef DATAPATH_DMEM_EN
            OP_LW:   begin wr_en = 1'b1; wr_addr = rt; wr_data = dmem[mem_idx]; end
            OP_SW:   dmem_we = 1'b1;
`else
            OP_LW, OP_SW: ;
`endif
            default: ;
        endcase
    end

    // a host write stalls the core for that cycle
    logic advance;
    assign advance = enable && !host.i_write_inst_mem;

    // ---------------- state ----------------
    // instruction memory survives reset so a program loaded under reset stays
    always_ff @(posedge clk) begin
        if (host.i_write_inst_mem)
            imem[host.i_inst_mem_addr[IMEM_ADDR_BITS-1:0]] <= host.i_inst_mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (advance) begin
            pc <= next_pc;
            if (wr_en && wr_addr != '0) rf[wr_addr] <= wr_data;
        end
    end

`ifdef DATAPATH_DMEM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**DMEM_ADDR_BITS; i++) dmem[i] <= '0;
        end else if (advance && dmem_we) begin
            dmem[mem_idx] <= rt_val;
        end
    end
`else
    logic unused_dmem_we;
    assign unused_dmem_we = dmem_we;
`endif

    logic unused_host_addr;
    assign unused_host_addr = ^host.i_inst_mem_addr[PC_BITS-1:IMEM_ADDR_BITS];

    genvar k;
    generate
        for (k = 0; k < NREGS; k++) begin : g_flat
            assign o_rf_regs[k*PROC_BITS +: PROC_BITS] = rf[k];
        end
    endgenerate
endmodule

// File: tb/tb_mips_datapath.sv
module tb_mips_datapath;
    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [1023:0]   o_rf_regs;
    int              checks = 0;
    int              errors = 0;

    mips_datapath_if #(.PC_BITS(32), .INSTRUCTION_BITS(32)) host_if ();

    mips_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .host      (host_if.slave),
        .o_rf_regs (o_rf_regs)
    );

    always #5 clk = ~clk;

    // program: word address -> instruction
    logic [31:0] prog [27];
    initial begin
        prog[0]  = 32'h20010005; // ADDI r1,r0,5
        prog[1]  = 32'h2002FFFD; // ADDI r2,r0,-3
        prog[2]  = 32'h00221821; // ADDU r3,r1,r2
        prog[3]  = 32'h10210002; // BEQ  r1,r1,+2 -> 6
        prog[4]  = 32'h20070063; // ADDI r7,r0,99 (skipped)
        prog[5]  = 32'h20070063; // ADDI r7,r0,99 (skipped)
        prog[6]  = 32'h3C041234; // LUI  r4,0x1234
        prog[7]  = 32'h34845678; // ORI  r4,r4,0x5678
        prog[8]  = 32'h0041282A; // SLT  r5,r2,r1
        prog[9]  = 32'h20000007; // ADDI r0,r0,7
        prog[10] = 32'h14210005; // BNE  r1,r1,+5 (not taken)
        prog[11] = 32'h21080001; // ADDI r8,r8,1
        prog[12] = 32'hAC010008; // SW   r1,8(r0)
        prog[13] = 32'h8C060008; // LW   r6,8(r0)
        prog[14] = 32'h00414823; // SUBU r9,r2,r1
        prog[15] = 32'h00825026; // XOR  r10,r4,r2
        prog[16] = 32'h00205827; // NOR  r11,r1,r0
        prog[17] = 32'h00026043; // SRA  r12,r2,1
        prog[18] = 32'h00026902; // SRL  r13,r2,4
        prog[19] = 32'h000170C0; // SLL  r14,r1,3
        prog[20] = 32'h284FFFFE; // SLTI r15,r2,-2
        prog[21] = 32'h3050FFFF; // ANDI r16,r2,0xFFFF
        prog[22] = 32'h38318000; // XORI r17,r1,0x8000
        prog[23] = 32'h2012001A; // ADDI r18,r0,26
        prog[24] = 32'h02400008; // JR   r18 -> 26
        prog[25] = 32'h20070063; // ADDI r7,r0,99 (skipped)
        prog[26] = 32'h08000000; // J    0
    end

    function automatic logic [31:0] reg_of(input int k);
        return o_rf_regs[k*32 +: 32];
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [31:0] addr, input logic [31:0] data);
        host_if.i_write_inst_mem = 1'b1;
        host_if.i_inst_mem_addr  = addr;
        host_if.i_inst_mem_data  = data;
        step(1);
        host_if.i_write_inst_mem = 1'b0;
    endtask

    logic [31:0] exp_r6;

    initial begin
`ifdef DATAPATH_DMEM_EN
        exp_r6 = 32'd5;
`else
        exp_r6 = 32'd0;
`endif
        rst = 1'b1;
        enable = 1'b0;
        host_if.i_write_inst_mem = 1'b0;
        host_if.i_inst_mem_addr  = '0;
        host_if.i_inst_mem_data  = '0;
        step(2);

        // clear imem under reset, then run NOPs
        for (int a = 0; a < 256; a++) host_write(a, 32'h0);
        checks++;
        assert (o_rf_regs === '0) else begin
            errors++; $error("FAIL reset_regs: observed nonzero expected all zero");
        end
        rst = 1'b0; enable = 1'b1;
        step(10);
        checks++;
        assert (o_rf_regs === '0) else begin
            errors++; $error("FAIL nop_regs: observed nonzero expected all zero");
        end

        // load program under reset (PC back to 0)
        rst = 1'b1; enable = 1'b0;
        for (int a = 0; a < 27; a++) host_write(a, prog[a]);
        step(1);
        rst = 1'b0; enable = 1'b1;

        step(1); check("addi_r1", reg_of(1), 32'd5);
        step(1); check("addi_neg_r2", reg_of(2), 32'hFFFFFFFD);
        step(1); check("addu_r3", reg_of(3), 32'd2);
        step(1);                                   // BEQ taken
        step(1); check("lui_r4", reg_of(4), 32'h12340000);
                 check("beq_skip_r7", reg_of(7), 32'd0);
        step(1); check("ori_r4", reg_of(4), 32'h12345678);

        // freeze for 4 cycles
        enable = 1'b0;
        step(4); check("hold_r4", reg_of(4), 32'h12345678);
                 check("hold_r5", reg_of(5), 32'd0);
        enable = 1'b1;
        step(1); check("slt_r5", reg_of(5), 32'd1);
        step(1); check("r0_zero", reg_of(0), 32'd0);
        step(1);                                   // BNE not taken
        step(1); check("bne_fall_r8", reg_of(8), 32'd1);

        // host write mid-run stalls the core one cycle
        host_write(32'd200, 32'h0);
        check("stall_r8", reg_of(8), 32'd1);
        step(1);                                   // SW
        step(1); check("lw_r6", reg_of(6), exp_r6);
        step(1); check("subu_r9", reg_of(9), 32'hFFFFFFF8);
        step(1); check("xor_r10", reg_of(10), 32'hEDCBA985);
        step(1); check("nor_r11", reg_of(11), 32'hFFFFFFFA);
        step(1); check("sra_r12", reg_of(12), 32'hFFFFFFFE);
        step(1); check("srl_r13", reg_of(13), 32'h0FFFFFFF);
        step(1); check("sll_r14", reg_of(14), 32'h00000028);
        step(1); check("slti_r15", reg_of(15), 32'd1);
        step(1); check("andi_r16", reg_of(16), 32'h0000FFFD);
        step(1); check("xori_r17", reg_of(17), 32'h00008005);
        step(1); check("addi_r18", reg_of(18), 32'd26);
        step(2);                                   // JR 26, J 0
        step(10);                                  // PCs 0,1,2,3,6..11
        check("loop_r8", reg_of(8), 32'd2);
        check("jr_skip_r7", reg_of(7), 32'd0);

        // reset mid-run clears registers but keeps imem
        rst = 1'b1;
        step(1); check("rst_r8", reg_of(8), 32'd0);
                 check("rst_r4", reg_of(4), 32'd0);
        rst = 1'b0;
        step(1); check("imem_kept_r1", reg_of(1), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
